store_merge_unit: RTL and testbench
===================================

# store_merge_unit

Store-side counterpart of the load data splitter: it takes a store request (address, 32-bit data, size code) and writes it to a word-only data memory with no byte enables. Word stores go straight through. Half-word and byte stores use a read-modify-write sequence: read the containing word, merge the new lanes, write the word back. The unit sits between the execute stage's store request and the data memory port, and holds the pipeline through `req_ready` until the store completes.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req_valid`  in  1: store request present.
- `req_ready`  out  1: unit idle and able to accept a request.
- `req_addr`  in  ADDR_W: byte address.
- `req_data`  in  32: store data; the low bits are used for sub-word stores.
- `req_size`  in  3: size code, shared with the load path (see Operation).
- `mem_addr`  out  ADDR_W: word-aligned address; bits [1:0] are always 0.
- `mem_re`  out  1: memory read strobe; read data returns on the following cycle.
- `mem_rdata`  in  32: memory read data.
- `mem_we`  out  1: memory write strobe.
- `mem_wdata`  out  32: full word to write.
- `done`  out  1: one-cycle pulse when the store has completed.
- `err`  out  1: qualifies `done`; high means the request was rejected and memory was not touched.

## Operation
- Size codes:
  - 000: word.
  - 001 and 010: half-word.
  - 011 and 100: byte.
  - Sign and zero variants behave identically for stores.
  - 101–111 are illegal: `err` is set and memory is not accessed.
- A request is accepted when `req_valid && req_ready`. On acceptance the unit latches address, data and size; later changes on the request inputs are ignored.
- States are IDLE, READ, WAIT, WRITE and DONE.
  - IDLE: `req_ready` is 1. An accepted word store goes to WRITE. An accepted sub-word store goes to READ. An accepted illegal or misaligned request goes to DONE with `err` set.
  - READ: `mem_re`=1 and `mem_addr` = the latched address with bits [1:0] cleared. Next state is WAIT.
  - WAIT: `mem_rdata` is valid in this cycle and is merged into the write register at the clock edge. Next state is WRITE.
  - WRITE: `mem_we`=1 with `mem_wdata` set to the merged word (or to the raw data for a word store). Next state is DONE.
  - DONE: `done`=1, and `err` carries the request's error status. Next state is IDLE.
- Merge rules (all other lanes keep the value read from memory):
  - Half-word: `addr[1]`=0 replaces [15:0]; `addr[1]`=1 replaces [31:16]. The new value is `req_data[15:0]`.
  - Byte: `addr[1:0]`=k replaces bits [8k+7:8k] with `req_data[7:0]`.
- Output values:
  - `mem_re`, `mem_we`, `done` and `err` are decoded from the state register.
  - `mem_wdata` and `mem_addr` come from registers.
  - In states where they are not strobed, `mem_wdata` and `mem_addr` hold their last value.
  - `err` is 0 outside DONE.

## Timing
- Reset behaviour:
  - The state register goes to IDLE.
  - `mem_re`, `mem_we`, `done`, `err`, `mem_addr` and `mem_wdata` are all 0.
  - `req_ready` is 0 while `rst` is high and 1 in the first cycle after `rst` is released.
- Latency, counted from the acceptance edge:
  - Word store: WRITE in cycle +1, `done` in cycle +2.
  - Sub-word store: READ +1, WAIT +2, WRITE +3, `done` +4.
  - Error: `done` and `err` in cycle +1, with no memory strobes.
- `req_ready` is low from the cycle after acceptance through DONE. A new request can be accepted in the cycle after DONE, so the minimum spacing is 3 cycles for word stores and 5 for sub-word stores.
- Reset asserted in any state aborts the operation in that cycle.
  - No `mem_we` is issued after the reset edge.
  - A store that was partly done is simply lost; memory is never left with a half-merged word.
- `mem_rdata` is sampled only in WAIT and ignored in all other states.

## Configuration
- `STORE_MERGE_ALIGN_CHECK_EN` defined:
  - A half-word with `addr[0]`=1 is rejected with `err`.
  - A word with `addr[1:0]`≠0 is rejected with `err`.
- Not defined:
  - The offending low address bits are ignored: half-words use `addr[1]` only, words use the aligned word.
  - Only illegal size codes raise `err`.

## Structure
- Shared package or header holds:
  - The size-code localparams (SZ_WORD, SZ_HALF_S, SZ_HALF_U, SZ_BYTE_S, SZ_BYTE_U), shared with the load splitter.
  - The state encodings.
- One combinational sub-module, `store_lane_merge`. Inputs: old word, new data, size, `addr[1:0]`. Output: the merged word. The FSM and registers stay in `store_merge_unit`.

## Test plan
- Word store: addr 0x100, data 0xDEADBEEF, size 000 → at +1 `mem_we`=1, `mem_addr`=0x100, `mem_wdata`=0xDEADBEEF; `done` at +2; `mem_re` never asserted.
- Byte store: addr 0x102, data 0x000000AB, size 100, with memory word 0x11223344 → `mem_re` at +1; `mem_wdata`=0x11AB3344 at +3; `done` at +4.
- Half-word store: addr 0x106, data 0xFFFF5A5A, size 001, with memory word 0x11223344 → `mem_wdata`=0x5A5A3344.
- Misaligned half-word at addr 0x101 with the macro defined → `done`=`err`=1 at +1, no strobes. With the macro undefined → lanes [15:0] are written.
- Illegal size 110 → `err`=1, no memory access. Back-to-back requests held valid → second acceptance in the cycle after the first `done`.
- Reset asserted in WAIT → no `mem_we` follows, all outputs are 0 during reset, and `req_ready` is 1 in the first cycle after reset is released.

Source files
------------

// File: rtl/store_merge_unit_pkg.sv
// -----------------------------------------------------------------------------
// store_merge_unit_pkg
// Shared definitions for the store merge unit and the load data splitter:
// size codes, FSM state encoding and small size-decode helpers.
// -----------------------------------------------------------------------------
package store_merge_unit_pkg;

  localparam logic [2:0] SZ_WORD   = 3'b000;
  localparam logic [2:0] SZ_HALF_S = 3'b001;
  localparam logic [2:0] SZ_HALF_U = 3'b010;
  localparam logic [2:0] SZ_BYTE_S = 3'b011;
  localparam logic [2:0] SZ_BYTE_U = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } sm_state_e;

  function automatic logic size_is_half(input logic [2:0] sz);
    return (sz == SZ_HALF_S) || (sz == SZ_HALF_U);
  endfunction

  function automatic logic size_is_illegal(input logic [2:0] sz);
    return sz > SZ_BYTE_U;
  endfunction

endpackage

// File: rtl/store_merge_unit_if.sv
// -----------------------------------------------------------------------------
// store_merge_unit_if
// Store request handshake plus word-only data memory port.
//   slave  : the store merge unit side (accepts requests, drives memory)
//   master : the pipeline / memory side (issues requests, returns read data)
// Signals: req_valid/req_ready/req_addr/req_data/req_size, mem_addr/mem_re/
// mem_rdata/mem_we/mem_wdata, done/err.
// -----------------------------------------------------------------------------
interface store_merge_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [2:0]        req_size;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              done;
  logic              err;

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_rdata,
    output req_ready, mem_addr, mem_re, mem_we, mem_wdata, done, err
  );

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_rdata,
    input  req_ready, mem_addr, mem_re, mem_we, mem_wdata, done, err
  );
endinterface

// File: rtl/store_lane_merge.sv
// -----------------------------------------------------------------------------
// store_lane_merge
// Combinational lane merge for sub-word stores.
// Ports:
//   old_word_i  : word read back from memory
//   new_data_i  : store data (low bits used for sub-word sizes)
//   size_i      : size code
//   addr_lo_i   : byte address bits [1:0]
//   merged_o    : word to write back
// Half-words select their lane with addr[1] only; addr[0] is ignored here.
// -----------------------------------------------------------------------------
module store_lane_merge
  import store_merge_unit_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_data_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_word_i;
    unique case (size_i)
      SZ_WORD: merged_o = new_data_i;
      SZ_HALF_S, SZ_HALF_U: begin
        if (addr_lo_i[1]) merged_o[31:16] = new_data_i[15:0];
        else              merged_o[15:0]  = new_data_i[15:0];
      end
      SZ_BYTE_S, SZ_BYTE_U: begin
        unique case (addr_lo_i)
          2'd0: merged_o[7:0]   = new_data_i[7:0];
          2'd1: merged_o[15:8]  = new_data_i[7:0];
          2'd2: merged_o[23:16] = new_data_i[7:0];
          2'd3: merged_o[31:24] = new_data_i[7:0];
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// -----------------------------------------------------------------------------
// store_merge_unit
// Writes store requests to a word-only memory. Word stores are written
// directly; half-word and byte stores read the containing word, merge the new
// lanes and write it back. req_ready holds the pipeline until done.
// Ports:
//   clk  : clock (rising edge)
//   rst  : synchronous active-high reset
//   bus  : store_merge_unit_if.slave (request handshake + memory port)
// Optional build macro: STORE_MERGE_ALIGN_CHECK_EN rejects misaligned
// half-word and word stores with err instead of ignoring the low bits.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | req_ready high, waiting for a request
// ST_READ  | mem_re high, reading the containing word
// ST_WAIT  | mem_rdata valid, merged into the write register at the edge
// ST_WRITE | mem_we high with the merged (or raw word) data
// ST_DONE  | done pulse, err reports rejection
// -----------------------------------------------------------------------------
module store_merge_unit
  import store_merge_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  store_merge_unit_if.slave bus
);

  sm_state_e         state_q, state_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [31:0]       data_q, data_d;
  logic [2:0]        size_q, size_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              accept;
  logic              req_err;
  logic [31:0]       merged;

  store_lane_merge u_merge (
    .old_word_i (bus.mem_rdata),
    .new_data_i (data_q),
    .size_i     (size_q),
    .addr_lo_i  (addr_lo_q),
    .merged_o   (merged)
  );

  assign accept = bus.req_valid && bus.req_ready;

`ifdef STORE_MERGE_ALIGN_CHECK_EN
  assign req_err = size_is_illegal(bus.req_size)
                || (size_is_half(bus.req_size) && bus.req_addr[0])
                || ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
  assign req_err = size_is_illegal(bus.req_size);
`endif

  always_comb begin
    state_d     = state_q;
    addr_lo_d   = addr_lo_q;
    data_d      = data_q;
    size_d      = size_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_lo_d = bus.req_addr[1:0];
          data_d    = bus.req_data;
          size_d    = bus.req_size;
          err_d     = req_err;
          if (req_err) begin
            // Rejected requests leave the memory-facing registers untouched.
            state_d = ST_DONE;
          end else begin
            mem_addr_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
            if (bus.req_size == SZ_WORD) begin
              mem_wdata_d = bus.req_data;
              state_d     = ST_WRITE;
            end else begin
              state_d = ST_READ;
            end
          end
        end
      end
      ST_READ:  state_d = ST_WAIT;
      ST_WAIT: begin
        mem_wdata_d = merged;
        state_d     = ST_WRITE;
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_lo_q   <= '0;
      data_q      <= '0;
      size_q      <= '0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_lo_q   <= addr_lo_d;
      data_q      <= data_d;
      size_q      <= size_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Strobes are masked by rst so an abort takes effect in the cycle reset
  // is raised: a pending write never reaches memory.
  assign bus.req_ready = (state_q == ST_IDLE)  && !rst;
  assign bus.mem_re    = (state_q == ST_READ)  && !rst;
  assign bus.mem_we    = (state_q == ST_WRITE) && !rst;
  assign bus.done      = (state_q == ST_DONE)  && !rst;
  assign bus.err       = (state_q == ST_DONE)  && err_q && !rst;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  store_merge_unit_if #(.ADDR_W(32)) ifc ();

  store_merge_unit #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data one cycle after mem_re, random junk otherwise.
  always @(posedge clk) begin
    if (ifc.mem_re) ifc.mem_rdata <= mem[ifc.mem_addr[9:2]];
    else            ifc.mem_rdata <= $urandom;
    if (ifc.mem_we) mem[ifc.mem_addr[9:2]] <= ifc.mem_wdata;
  end

`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, (obs), (exp)); \
    end \
  end

  // Reference: a store writes nbytes consecutive bytes starting at a lane
  // offset inside the word; everything else keeps the old memory value.
  task automatic ref_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] sz, input logic [31:0] old_w,
                           output bit e, output logic [31:0] w, output int lat);
    int nb;
    int off;
    e = (sz > 3'd4);
    if (sz == 3'd0)                   nb = 4;
    else if (sz == 3'd1 || sz == 3'd2) nb = 2;
    else                               nb = 1;
`ifdef STORE_MERGE_ALIGN_CHECK_EN
    if (nb == 4 && a[1:0] != 2'b00) e = 1;
    if (nb == 2 && a[0]) e = 1;
`endif
    if (nb == 4)      off = 0;
    else if (nb == 2) off = a[1] ? 2 : 0;
    else              off = int'(a[1:0]);
    w = old_w;
    for (int i = 0; i < nb; i++) w[8*(off+i) +: 8] = d[8*i +: 8];
    if (e)            lat = 1;
    else if (nb == 4) lat = 2;
    else              lat = 4;
  endtask

  task automatic cmp_mem(input string tag);
    int nmis;
    nmis = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nmis++;
    `CHK(tag, nmis, 0)
  endtask

  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    bit          exp_err;
    logic [31:0] exp_w;
    int          exp_lat;
    int          done_c, we_c, re_n, we_n, rdy_n, stray_err;
    logic        err_o;
    logic [31:0] we_addr, we_data, re_addr;
    ref_store(a, d, sz, ref_mem[a[9:2]], exp_err, exp_w, exp_lat);
    @(negedge clk);
    `CHK("ready_idle", ifc.req_ready, 1'b1)
    ifc.req_valid = 1'b1;
    ifc.req_addr  = a;
    ifc.req_data  = d;
    ifc.req_size  = sz;
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    ifc.req_addr  = $urandom;
    ifc.req_data  = $urandom;
    ifc.req_size  = 3'($urandom);
    done_c = -1; we_c = -1; re_n = 0; we_n = 0; rdy_n = 0; stray_err = 0;
    err_o = 1'bx; we_addr = 'x; we_data = 'x; re_addr = 'x;
    for (int c = 1; c <= 8 && done_c < 0; c++) begin
      @(negedge clk);
      if (ifc.mem_re) begin re_n++; re_addr = ifc.mem_addr; end
      if (ifc.mem_we) begin we_n++; we_c = c; we_addr = ifc.mem_addr; we_data = ifc.mem_wdata; end
      if (ifc.req_ready) rdy_n++;
      if (ifc.done) begin done_c = c; err_o = ifc.err; end
      else if (ifc.err) stray_err++;
    end
    `CHK("done_latency", done_c, exp_lat)
    `CHK("err", err_o, exp_err)
    `CHK("ready_low_busy", rdy_n, 0)
    `CHK("err_outside_done", stray_err, 0)
    `CHK("re_count", re_n, (exp_err || exp_lat == 2) ? 0 : 1)
    `CHK("we_count", we_n, exp_err ? 0 : 1)
    if (!exp_err) begin
      `CHK("we_cycle", we_c, exp_lat - 1)
      `CHK("we_addr", we_addr, {a[31:2], 2'b00})
      `CHK("we_data", we_data, exp_w)
      if (exp_lat == 4) `CHK("re_addr", re_addr, {a[31:2], 2'b00})
      ref_mem[a[9:2]] = exp_w;
    end
    cmp_mem("mem_image");
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    mem[a[9:2]]     = w;
    ref_mem[a[9:2]] = w;
  endtask

  initial begin
    int rdy_c;
    int d1_c;
    int we_after_rst;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    rst           = 1'b1;
    ifc.req_valid = 1'b0;
    ifc.req_addr  = '0;
    ifc.req_data  = '0;
    ifc.req_size  = '0;
    repeat (3) @(negedge clk);
    `CHK("rst_ready", ifc.req_ready, 1'b0)
    `CHK("rst_re", ifc.mem_re, 1'b0)
    `CHK("rst_we", ifc.mem_we, 1'b0)
    `CHK("rst_done", ifc.done, 1'b0)
    `CHK("rst_err", ifc.err, 1'b0)
    `CHK("rst_addr", ifc.mem_addr, 32'h0)
    `CHK("rst_wdata", ifc.mem_wdata, 32'h0)
    rst = 1'b0;

    // Directed cases from the test plan.
    run_store(32'h100, 32'hDEADBEEF, 3'b000);
    `CHK("tp_word", mem[8'h40], 32'hDEADBEEF)
    set_word(32'h100, 32'h11223344);
    run_store(32'h102, 32'h000000AB, 3'b100);
    `CHK("tp_byte", mem[8'h40], 32'h11AB3344)
    set_word(32'h104, 32'h11223344);
    run_store(32'h106, 32'hFFFF5A5A, 3'b001);
    `CHK("tp_half", mem[8'h41], 32'h5A5A3344)
    set_word(32'h100, 32'h11223344);
    run_store(32'h101, 32'h0000BEEF, 3'b010);
    run_store(32'h104, 32'h12345678, 3'b110);
    run_store(32'h10B, 32'hCAFEF00D, 3'b000);
    run_store(32'h10F, 32'h000000EE, 3'b011);

    // Random stores across all size codes and alignments.
    for (int n = 0; n < 40; n++)
      run_store(32'($urandom_range(0, 1023)), $urandom, 3'($urandom_range(0, 7)));

    // Back-to-back: request held valid, second accept right after first done.
    @(negedge clk);
    ifc.req_valid = 1'b1;
    ifc.req_addr  = 32'h200;
    ifc.req_data  = 32'hA5A5A5A5;
    ifc.req_size  = 3'b000;
    @(posedge clk);
    #1;
    ifc.req_addr = 32'h204;
    ifc.req_data = 32'h0F0F0F0F;
    d1_c = -1; rdy_c = -1;
    for (int c = 1; c <= 8 && rdy_c < 0; c++) begin
      @(negedge clk);
      if (ifc.done) d1_c = c;
      if (ifc.req_ready) rdy_c = c;
    end
    `CHK("b2b_done1", d1_c, 2)
    `CHK("b2b_accept2", rdy_c, d1_c + 1)
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    d1_c = -1;
    for (int c = 1; c <= 8 && d1_c < 0; c++) begin
      @(negedge clk);
      if (ifc.done) d1_c = c;
    end
    `CHK("b2b_done2", d1_c, 2)
    ref_mem[8'h80] = 32'hA5A5A5A5;
    ref_mem[8'h81] = 32'h0F0F0F0F;
    cmp_mem("b2b_mem");

    // Reset during WAIT of a byte store aborts it with no write.
    set_word(32'h300, 32'h55667788);
    @(negedge clk);
    ifc.req_valid = 1'b1;
    ifc.req_addr  = 32'h301;
    ifc.req_data  = 32'h000000CC;
    ifc.req_size  = 3'b011;
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    @(negedge clk);
    `CHK("abort_read", ifc.mem_re, 1'b1)
    @(negedge clk);
    rst = 1'b1;
    we_after_rst = 0;
    #1;
    if (ifc.mem_we) we_after_rst++;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (ifc.mem_we) we_after_rst++;
      `CHK("abort_rst_ready", ifc.req_ready, 1'b0)
      `CHK("abort_rst_re", ifc.mem_re, 1'b0)
      `CHK("abort_rst_done", ifc.done, 1'b0)
      `CHK("abort_rst_err", ifc.err, 1'b0)
      `CHK("abort_rst_addr", ifc.mem_addr, 32'h0)
      `CHK("abort_rst_wdata", ifc.mem_wdata, 32'h0)
    end
    rst = 1'b0;
    @(negedge clk);
    `CHK("abort_ready_after", ifc.req_ready, 1'b1)
    for (int c = 0; c < 4; c++) begin
      if (ifc.mem_we) we_after_rst++;
      @(negedge clk);
    end
    `CHK("abort_no_we", we_after_rst, 0)
    `CHK("abort_word", mem[8'hC0], 32'h55667788)
    cmp_mem("abort_mem");

    run_store(32'h302, 32'h00009999, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
